pe_bram_responder: RTL

Memory-side responder for the PE array's BRAM port. It holds the word-addressed vector, matrix and result image, and answers the array's address/write-enable/read-data interface with a fixed one-cycle read latency. A simple host port fills and drains that image while the array is idle. A small controller pulses `start`, waits for the array's `done`, then raises a sticky completion flag with a cycle count.

---
 rtl/pe_bram_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/pe_bram_responder.sv
// pe_bram_responder: word-addressed BRAM image with host fill/drain port and a start/done run controller.
// Define PE_BRAM_OOB_CHECK_EN to flag and suppress array accesses carrying stray address bits.
module pe_bram_responder #(
    parameter int ADDR_W     = 8,
    parameter int START_HOLD = 1
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [31:0]       BRAM_ADDR,
    input  logic [31:0]       BRAM_WRDATA,
    input  logic [3:0]        BRAM_WE,
    output logic [31:0]       BRAM_RDDATA,
    output logic              start,
    input  logic              done,
    input  logic              host_go,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic              busy,
    output logic              irq,
    input  logic              irq_clr,
    output logic [31:0]       cycle_cnt,
    output logic              oob_err
);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] hold_cnt;
    logic alive, go, h_acc, a_act, oob;
    logic [ADDR_W-1:0] a_idx;
    logic [31:0] mem [2**ADDR_W];

    assign a_idx      = BRAM_ADDR[ADDR_W+1:2];
    assign a_act      = state == START || state == RUN;
    assign host_ready = alive && state == IDLE;
    assign h_acc      = host_valid && host_ready;
    assign go         = host_go && host_ready;
    assign start      = state == START;
    assign busy       = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? START : IDLE;
            START:   state_nx = hold_cnt == 4'(START_HOLD - 1) ? RUN : START;
            RUN:     state_nx = done ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // alive keeps host_ready low until the first edge after reset release
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state       <= IDLE;
            hold_cnt    <= 4'd0;
            alive       <= 1'b0;
            irq         <= 1'b0;
            cycle_cnt   <= 32'd0;
            host_rvalid <= 1'b0;
            host_rdata  <= 32'd0;
            BRAM_RDDATA <= 32'd0;
        end else begin
            state       <= state_nx;
            alive       <= 1'b1;
            hold_cnt    <= state == START ? hold_cnt + 4'd1 : 4'd0;
            irq         <= state == DONE || (irq && !irq_clr && !go);
            cycle_cnt   <= go ? 32'd0 : (state == RUN && cycle_cnt != '1) ? cycle_cnt + 32'd1 : cycle_cnt;
            host_rvalid <= h_acc && !host_we;
            if (h_acc && !host_we) host_rdata <= mem[host_addr];
            if (a_act) BRAM_RDDATA <= oob ? 32'd0 : mem[a_idx];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (h_acc && host_we) mem[host_addr] <= host_wdata;
        else if (a_act && !oob)
            for (int k = 0; k < 4; k++)
                if (BRAM_WE[k]) mem[a_idx][8*k +: 8] <= BRAM_WRDATA[8*k +: 8];
    end

`ifdef PE_BRAM_OOB_CHECK_EN
    assign oob = |BRAM_ADDR[31:ADDR_W+2] || |BRAM_ADDR[1:0];
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) oob_err <= 1'b0;
        else if (a_act && oob) oob_err <= 1'b1;
    end
`else
    logic unused_addr;
    assign unused_addr = ^{BRAM_ADDR[31:ADDR_W+2], BRAM_ADDR[1:0]};
    assign oob         = 1'b0;
    assign oob_err     = 1'b0;
`endif
endmodule
